mseq_seed_scheduler: RTL and testbench

MSEQ_SEED_SCHEDULER -- requirements
Module: mseq_seed_scheduler

---
 rtl/mseq_seed_scheduler.sv | 156 +++++++++++++++
 tb/tb_mseq_seed_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mseq_seed_scheduler.sv
// mseq_seed_scheduler
// Collects two consecutive chaotic-state samples into one M-sequence seed word
// and hands each seed to one requesting generator channel, round-robin.
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   calcu_ctrl        run enable; low returns to IDLE and discards any seed
//   n1_valid          strobe qualifying xn1/yn1/zn1
//   xn1, yn1, zn1     chaotic state words
//   mseq_req          per-channel reseed request pulses
//   MSEQ_din          issued seed word, held between grants
//   MSEQ_din_valid    one-hot, one-cycle load strobe to the granted channel
//   seed_count        seeds issued (wrapping)
//   drop_count        samples discarded while a seed waits (saturating)
//   busy              high whenever the FSM is not IDLE
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | disabled; samples ignored, waiting for calcu_ctrl
// COLL_A   | waiting for first sample (x, y, z of word A)
// COLL_B   | waiting for second sample (x and upper half of y)
// SEED_RDY | seed complete; grant to a pending channel or hold it
module mseq_seed_scheduler #(
   parameter int DATA_WIDTH       = 64,
   parameter int INPUT_DATA_WIDTH = 4*DATA_WIDTH + DATA_WIDTH/2,
   parameter int NUM_CH           = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        calcu_ctrl,
   input  logic                        n1_valid,
   input  logic [DATA_WIDTH-1:0]       xn1,
   input  logic [DATA_WIDTH-1:0]       yn1,
   input  logic [DATA_WIDTH-1:0]       zn1,
   input  logic [NUM_CH-1:0]           mseq_req,
   output logic [INPUT_DATA_WIDTH-1:0] MSEQ_din,
   output logic [NUM_CH-1:0]           MSEQ_din_valid,
   output logic [15:0]                 seed_count,
   output logic [7:0]                  drop_count,
   output logic                        busy
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int A_W  = 3*DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLL_A   = 2'd1,
      COLL_B   = 2'd2,
      SEED_RDY = 2'd3
   } state_t;

   state_t                      state;
   state_t                      state_nxt;
   logic                        cap_a;
   logic                        cap_b;
   logic                        grant;
   logic                        drop;

   logic [NUM_CH-1:0]           pending;
   logic [CH_W-1:0]             last_grant;
   logic [CH_W-1:0]             grant_idx;
   logic [CH_W-1:0]             probe;
   logic                        grant_found;
   logic [NUM_CH-1:0]           grant_mask;

   logic [A_W-1:0]              a_word;
   logic [INPUT_DATA_WIDTH-1:0] seed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // calcu_ctrl low beats n1_valid and any pending grant
   always_comb begin
      state_nxt = state;
      cap_a     = 1'b0;
      cap_b     = 1'b0;
      grant     = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (calcu_ctrl) state_nxt = COLL_A;
         end
         COLL_A: begin
            if (!calcu_ctrl) state_nxt = IDLE;
            else if (n1_valid) begin
               cap_a     = 1'b1;
               state_nxt = COLL_B;
            end
         end
         COLL_B: begin
            if (!calcu_ctrl) state_nxt = IDLE;
            else if (n1_valid) begin
               cap_b     = 1'b1;
               state_nxt = SEED_RDY;
            end
         end
         SEED_RDY: begin
            if (!calcu_ctrl) state_nxt = IDLE;
            else if (|pending) begin
               grant     = 1'b1;
               state_nxt = COLL_A;
            end
            else if (n1_valid) drop = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // round-robin search starting one past the last granted channel
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      probe       = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         probe = CH_W'((int'(last_grant) + k) % NUM_CH);
         if (!grant_found && pending[probe]) begin
            grant_found = 1'b1;
            grant_idx   = probe;
         end
      end
   end

   assign grant_mask = grant ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending        <= '1;
         last_grant     <= CH_W'(NUM_CH-1);
         a_word         <= '0;
         seed           <= '0;
         MSEQ_din       <= '0;
         MSEQ_din_valid <= '0;
         seed_count     <= '0;
         drop_count     <= '0;
      end
      else begin
         // a request arriving with the grant keeps the bit set
         pending        <= (pending & ~grant_mask) | mseq_req;
         MSEQ_din_valid <= grant_mask;
         if (cap_a) a_word <= {xn1, yn1, zn1};
         if (cap_b) seed   <= {a_word, xn1, yn1[DATA_WIDTH-1 -: DATA_WIDTH/2]};
         if (grant) begin
            MSEQ_din   <= seed;
            last_grant <= grant_idx;
            seed_count <= seed_count + 16'd1;
         end
         if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mseq_seed_scheduler.sv
module tb_mseq_seed_scheduler;

   logic         clk;
   logic         rst_n;
   logic         calcu_ctrl;
   logic         n1_valid;
   logic [63:0]  xn1, yn1, zn1;
   logic [3:0]   mseq_req;
   logic [287:0] MSEQ_din;
   logic [3:0]   MSEQ_din_valid;
   logic [15:0]  seed_count;
   logic [7:0]   drop_count;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;

   mseq_seed_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .calcu_ctrl     (calcu_ctrl),
      .n1_valid       (n1_valid),
      .xn1            (xn1),
      .yn1            (yn1),
      .zn1            (zn1),
      .mseq_req       (mseq_req),
      .MSEQ_din       (MSEQ_din),
      .MSEQ_din_valid (MSEQ_din_valid),
      .seed_count     (seed_count),
      .drop_count     (drop_count),
      .busy           (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [287:0] got, input logic [287:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // The model thinks in terms of "enabled", "how many samples gathered" and
   // a list of channels that still want a seed.
   bit           m_on    = 1'b0;
   int           m_words = 0;
   logic [191:0] m_a     = '0;
   logic [287:0] m_seed  = '0;
   bit   [3:0]   m_want  = 4'hF;
   int           m_last  = 3;
   int           m_pick;
   logic [287:0] exp_din   = '0;
   logic [3:0]   exp_valid = '0;
   int           exp_seeds = 0;
   int           exp_drop  = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_on = 1'b0; m_words = 0; m_a = '0; m_seed = '0; m_want = 4'hF; m_last = 3;
         exp_din = '0; exp_valid = '0; exp_seeds = 0; exp_drop = 0;
      end
      else begin
         exp_valid = '0;
         m_pick    = -1;
         if (!m_on) begin
            if (calcu_ctrl) begin m_on = 1'b1; m_words = 0; end
         end
         else if (!calcu_ctrl) m_on = 1'b0;
         else if (m_words == 0) begin
            if (n1_valid) begin m_a = {xn1, yn1, zn1}; m_words = 1; end
         end
         else if (m_words == 1) begin
            if (n1_valid) begin m_seed = {m_a, xn1, yn1[63:32]}; m_words = 2; end
         end
         else if (m_want != 0) begin
            for (int d = 1; d <= 4; d++)
               if (m_pick < 0 && m_want[(m_last + d) % 4]) m_pick = (m_last + d) % 4;
            exp_din   = m_seed;
            exp_valid = 4'(1 << m_pick);
            exp_seeds = (exp_seeds + 1) % 65536;
            m_last    = m_pick;
            m_words   = 0;
         end
         else if (n1_valid && exp_drop < 255) exp_drop++;
         if (m_pick >= 0) m_want[m_pick] = 1'b0;
         m_want = m_want | mseq_req;
      end
   end

   // ---------------- per-cycle compare + grant log ----------------
   int           glog[$];
   logic [287:0] dlog[$];

   always @(negedge clk) begin
      chk("cyc_valid", {284'd0, MSEQ_din_valid}, {284'd0, exp_valid});
      chk("cyc_din", MSEQ_din, exp_din);
      chk("cyc_seed_count", {272'd0, seed_count}, 288'(exp_seeds));
      chk("cyc_drop_count", {280'd0, drop_count}, 288'(exp_drop));
      chk("cyc_busy", {287'd0, busy}, {287'd0, m_on});
      for (int i = 0; i < 4; i++)
         if (MSEQ_din_valid[i]) begin glog.push_back(i); dlog.push_back(MSEQ_din); end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit v, input logic [3:0] r);
      @(negedge clk);
      n1_valid = v;
      xn1      = {$urandom, $urandom};
      yn1      = {$urandom, $urandom};
      zn1      = {$urandom, $urandom};
      mseq_req = r;
   endtask

   logic [63:0]  wx[8], wy[8], wz[8];
   logic [287:0] want_din;
   int           base;

   initial begin
      rst_n = 1'b0; calcu_ctrl = 1'b0; n1_valid = 1'b0;
      xn1 = '0; yn1 = '0; zn1 = '0; mseq_req = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {287'd0, busy}, 288'd0);
      chk("rst_din", MSEQ_din, 288'd0);
      chk("rst_seed_count", {272'd0, seed_count}, 288'd0);

      // initial seeding: all four channels pending after reset
      rst_n = 1'b1;
      calcu_ctrl = 1'b1;
      cyc(0, 4'h0);
      for (int s = 0; s < 4; s++) begin
         cyc(1, 4'h0); wx[2*s] = xn1; wy[2*s] = yn1; wz[2*s] = zn1;
         cyc(1, 4'h0); wx[2*s+1] = xn1; wy[2*s+1] = yn1; wz[2*s+1] = zn1;
         cyc(0, 4'h0);
      end
      cyc(0, 4'h0); cyc(0, 4'h0);
      @(negedge clk);
      chk("init_grant_count", 288'(glog.size()), 288'd4);
      for (int s = 0; s < 4 && s < glog.size(); s++) begin
         want_din = {wx[2*s], wy[2*s], wz[2*s], wx[2*s+1], wy[2*s+1][63:32]};
         chk("init_grant_ch", 288'(glog[s]), 288'(s));
         chk("init_grant_din", dlog[s], want_din);
      end
      chk("init_seed_count", {272'd0, seed_count}, 288'd4);

      // two simultaneous requests: wrap from channel 3 serves 0 before 2
      base = glog.size();
      cyc(0, 4'b0101);
      repeat (2) begin cyc(1, 4'h0); cyc(1, 4'h0); cyc(0, 4'h0); end
      cyc(0, 4'h0); @(negedge clk);
      chk("rr_count", 288'(glog.size() - base), 288'd2);
      if (glog.size() >= base + 2) begin
         chk("rr_first", 288'(glog[base]), 288'd0);
         chk("rr_second", 288'(glog[base+1]), 288'd2);
      end

      // held seed with nobody pending: drops saturate, nothing issued
      base = glog.size();
      cyc(1, 4'h0); cyc(1, 4'h0);
      repeat (300) cyc(1, 4'h0);
      cyc(0, 4'h0); @(negedge clk);
      chk("drop_sat", {280'd0, drop_count}, 288'd255);
      chk("drop_no_strobe", 288'(glog.size() - base), 288'd0);
      cyc(0, 4'b0010); cyc(0, 4'h0); cyc(0, 4'h0); @(negedge clk);
      chk("drop_then_grant_count", 288'(glog.size() - base), 288'd1);
      if (glog.size() > base) chk("drop_then_grant_ch", 288'(glog[base]), 288'd1);

      // request arriving in the grant cycle of the same channel survives
      base = glog.size();
      cyc(0, 4'b1000);
      cyc(1, 4'h0); cyc(1, 4'h0);
      cyc(0, 4'b1000);
      cyc(1, 4'h0); cyc(1, 4'h0); cyc(0, 4'h0); cyc(0, 4'h0); @(negedge clk);
      chk("req_in_grant_count", 288'(glog.size() - base), 288'd2);
      if (glog.size() >= base + 2) begin
         chk("req_in_grant_first", 288'(glog[base]), 288'd3);
         chk("req_in_grant_second", 288'(glog[base+1]), 288'd3);
      end

      // abort mid-collection; the next seed is built only from fresh words
      base = glog.size();
      cyc(0, 4'b0010);
      cyc(1, 4'h0);
      @(negedge clk); calcu_ctrl = 1'b0; n1_valid = 1'b0; mseq_req = '0;
      @(negedge clk);
      chk("abort_busy", {287'd0, busy}, 288'd0);
      calcu_ctrl = 1'b1;
      cyc(1, 4'h0); wx[0] = xn1; wy[0] = yn1; wz[0] = zn1;
      cyc(1, 4'h0); wx[1] = xn1; wy[1] = yn1;
      cyc(0, 4'h0); cyc(0, 4'h0); @(negedge clk);
      chk("abort_grant_count", 288'(glog.size() - base), 288'd1);
      if (glog.size() > base) begin
         chk("abort_grant_ch", 288'(glog[base]), 288'd1);
         chk("abort_din", dlog[base], {wx[0], wy[0], wz[0], wx[1], wy[1][63:32]});
      end

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         calcu_ctrl = ($urandom_range(0, 39) != 0);
         n1_valid   = $urandom_range(0, 1) == 1;
         xn1 = {$urandom, $urandom}; yn1 = {$urandom, $urandom}; zn1 = {$urandom, $urandom};
         mseq_req   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      end

      // reset one cycle after the second sample: no strobe may escape
      @(negedge clk); calcu_ctrl = 1'b0; n1_valid = 1'b0; mseq_req = 4'hF;
      @(negedge clk); calcu_ctrl = 1'b1; mseq_req = 4'h0;
      cyc(1, 4'h0); cyc(1, 4'h0);
      @(negedge clk); n1_valid = 1'b0;
      base = glog.size();
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_valid", {284'd0, MSEQ_din_valid}, 288'd0);
      chk("rstmid_din", MSEQ_din, 288'd0);
      chk("rstmid_busy", {287'd0, busy}, 288'd0);
      chk("rstmid_drop", {280'd0, drop_count}, 288'd0);
      chk("rstmid_seeds", {272'd0, seed_count}, 288'd0);
      repeat (3) @(negedge clk);
      chk("rstmid_no_strobe", 288'(glog.size() - base), 288'd0);
      rst_n = 1'b1;
      repeat (10) cyc(1, 4'h0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
